// File: rtl/bd_tx_scheduler_pkg.sv
// Shared constants and types for the USB bulk TX byte scheduler.
// PID/SYNC bytes, CRC16 parameters, packet kind and FSM state encodings.
package bd_tx_scheduler_pkg;

    localparam logic [7:0]  SYNC_BYTE  = 8'h80;
    localparam logic [7:0]  PID_ACK    = 8'hD2;
    localparam logic [7:0]  PID_NAK    = 8'h5A;
    localparam logic [7:0]  PID_DATA0  = 8'hC3;
    localparam logic [7:0]  PID_DATA1  = 8'h4B;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        KIND_ACK,
        KIND_NAK,
        KIND_DATA
    } tx_kind_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_PAYLOAD,
        ST_CRC_LO,
        ST_CRC_HI,
        ST_EOP,
        ST_DONE
    } tx_state_t;

    // USB shifts the CRC LSB-first, so the register works on the bit-reversed polynomial.
    function automatic logic [15:0] reflect16(input logic [15:0] v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[i] = v[15-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/bd_tx_scheduler_if.sv
// Request, FIFO and encoder-side signals of the bulk TX scheduler.
// master = controller/FIFO/encoder environment, slave = scheduler.
interface bd_tx_scheduler_if #(
    parameter int CNT_W = 7
);
    logic             tx_en;
    logic             send_ack;
    logic             send_nack;
    logic             send_data;
    logic             host_ack;
    logic [CNT_W-1:0] fifo_count;
    logic [7:0]       fifo_rdata;
    logic             fifo_rd;
    logic [7:0]       tx_byte;
    logic             tx_valid;
    logic             tx_ready;
    logic             tx_eop;
    logic             txing;
    logic             tx_complete;

    modport master (
        output tx_en, send_ack, send_nack, send_data, host_ack,
        output fifo_count, fifo_rdata, tx_ready,
        input  fifo_rd, tx_byte, tx_valid, tx_eop, txing, tx_complete
    );

    modport slave (
        input  tx_en, send_ack, send_nack, send_data, host_ack,
        input  fifo_count, fifo_rdata, tx_ready,
        output fifo_rd, tx_byte, tx_valid, tx_eop, txing, tx_complete
    );
endinterface

// File: rtl/bd_tx_scheduler_crc16.sv
// USB CRC16 update over one payload byte (reflected form, LSB first).
// Latency: combinational.
// Backpressure: none; caller decides when to register crc_out.
module bd_tx_scheduler_crc16
    import bd_tx_scheduler_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_byte,
    output logic [15:0] crc_out
);
    localparam logic [15:0] POLY_REFL = reflect16(CRC16_POLY);

    logic [15:0] c;

    always_comb begin
        c = crc_in ^ {8'h00, data_byte};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
        end
        crc_out = c;
    end
endmodule

// File: rtl/bd_tx_scheduler.sv
// Bulk TX byte sequencer: SYNC, PID, payload, CRC16, EOP; owns the DATA0/DATA1 toggle.
// Latency: request cycle -> SYNC valid next cycle; one byte per tx_valid&tx_ready handshake.
// Backpressure: tx_byte/tx_valid held while tx_ready low; FIFO popped only on accepted payload bytes.
module bd_tx_scheduler
    import bd_tx_scheduler_pkg::*;
#(
    parameter int MAX_PKT = 64,
    parameter int CNT_W   = 7
) (
    input logic              clk,
    input logic              n_rst,
    bd_tx_scheduler_if.slave bus
);
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_PKT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    tx_state_t        state, state_nxt;
    tx_kind_t         kind;
    logic [CNT_W-1:0] len;
    logic [15:0]      crc, crc_upd;
    logic             toggle, last_data;
    logic             req;
    logic [7:0]       pid_byte;

    assign req       = bus.tx_en & (bus.send_nack | bus.send_ack | bus.send_data);
    assign bus.txing = (state != ST_IDLE);

    bd_tx_scheduler_crc16 u_crc (
        .crc_in    (crc),
        .data_byte (bus.fifo_rdata),
        .crc_out   (crc_upd)
    );

    always_comb begin
        case (kind)
            KIND_NAK: pid_byte = PID_NAK;
            KIND_ACK: pid_byte = PID_ACK;
            default:  pid_byte = toggle ? PID_DATA1 : PID_DATA0;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            kind      <= KIND_ACK;
            len       <= '0;
            crc       <= '0;
            toggle    <= 1'b0;
            last_data <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && req) begin
                crc <= CRC16_INIT;
                if (bus.send_nack) begin
                    kind <= KIND_NAK;
                end else if (bus.send_ack) begin
                    kind <= KIND_ACK;
                end else begin
                    kind <= KIND_DATA;
                    len  <= (bus.fifo_count > MAX_LEN) ? MAX_LEN : bus.fifo_count;
                end
            end
            if (state == ST_PAYLOAD && bus.tx_ready) begin
                crc <= crc_upd;
                len <= len - ONE;
            end
            // Only a host ACK seen in IDLE after a completed DATA packet may flip the toggle.
            if (state == ST_DONE) begin
                last_data <= (kind == KIND_DATA);
            end else if (state == ST_IDLE && bus.host_ack && last_data) begin
                toggle    <= ~toggle;
                last_data <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        bus.tx_byte     = 8'h00;
        bus.tx_valid    = 1'b0;
        bus.fifo_rd     = 1'b0;
        bus.tx_eop      = 1'b0;
        bus.tx_complete = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) state_nxt = ST_SYNC;
            end
            ST_SYNC: begin
                bus.tx_valid = 1'b1;
                bus.tx_byte  = SYNC_BYTE;
                if (bus.tx_ready) state_nxt = ST_PID;
            end
            ST_PID: begin
                bus.tx_valid = 1'b1;
                bus.tx_byte  = pid_byte;
                if (bus.tx_ready) begin
                    if (kind != KIND_DATA) state_nxt = ST_EOP;
                    else if (len != '0)    state_nxt = ST_PAYLOAD;
                    else                   state_nxt = ST_CRC_LO;
                end
            end
            ST_PAYLOAD: begin
                bus.tx_valid = 1'b1;
                bus.tx_byte  = bus.fifo_rdata;
                if (bus.tx_ready) begin
                    bus.fifo_rd = 1'b1;
                    if (len == ONE) state_nxt = ST_CRC_LO;
                end
            end
            ST_CRC_LO: begin
                bus.tx_valid = 1'b1;
                bus.tx_byte  = ~crc[7:0];
                if (bus.tx_ready) state_nxt = ST_CRC_HI;
            end
            ST_CRC_HI: begin
                bus.tx_valid = 1'b1;
                bus.tx_byte  = ~crc[15:8];
                if (bus.tx_ready) state_nxt = ST_EOP;
            end
            ST_EOP: begin
                bus.tx_eop = 1'b1;
                state_nxt  = ST_DONE;
            end
            ST_DONE: begin
                bus.tx_complete = 1'b1;
                state_nxt       = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end
endmodule
